// File: rtl/rf_seq_pkg.sv
// Shared types for the register-file command sequencer: command opcodes,
// FSM states and default port widths.
package rf_seq_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_COPY  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RSP
  } state_t;

endpackage

// File: rtl/rf_cmd_seq.sv
// Initiator for the register-file port: runs WRITE/READ/COPY commands and
// returns read data over a valid/ready response channel.
module rf_cmd_seq
  import rf_seq_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int READ_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [1:0]        CMD_OP,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic [ADDR_W-1:0] CMD_SRC,
  input  logic [DATA_W-1:0] CMD_DATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_DATA,
  output logic              RF_EN,
  output logic [ADDR_W-1:0] RF_ADDR,
  output logic [DATA_W-1:0] RF_IN,
  input  logic [DATA_W-1:0] RF_OUT,
  output logic              BUSY
);

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT - 1);

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] rda_q, rda_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      dst_q   <= '0;
      rda_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      rda_q   <= rda_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dst_d   = dst_q;
    rda_d   = rda_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (CMD_VALID) begin
          op_d   = op_t'(CMD_OP);
          dst_d  = CMD_ADDR;
          rda_d  = (op_t'(CMD_OP) == OP_COPY) ? CMD_SRC : CMD_ADDR;
          data_d = CMD_DATA;
          cnt_d  = '0;
          unique case (op_t'(CMD_OP))
            OP_WRITE:         state_d = S_WR;
            OP_READ, OP_COPY: state_d = S_RD;
            default:          state_d = S_IDLE;
          endcase
        end
      end
      S_RD: begin
        // RF_OUT is taken on the edge that closes the last latency cycle.
        if (cnt_q == CNT_LAST) begin
          data_d  = RF_OUT;
          cnt_d   = '0;
          state_d = (op_q == OP_COPY) ? S_WR : S_RSP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WR:  state_d = S_IDLE;
      S_RSP: if (RSP_READY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Port outputs depend only on registered state; RST gates CMD_READY low.
  always_comb begin
    CMD_READY = 1'b0;
    RSP_VALID = 1'b0;
    RSP_DATA  = '0;
    RF_EN     = 1'b0;
    RF_ADDR   = '0;
    RF_IN     = '0;
    BUSY      = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: CMD_READY = RST;
      S_WR: begin
        RF_EN   = 1'b1;
        RF_ADDR = dst_q;
        RF_IN   = data_q;
      end
      S_RD:  RF_ADDR = rda_q;
      S_RSP: begin
        RSP_VALID = 1'b1;
        RSP_DATA  = data_q;
      end
      default: ;
    endcase
  end

endmodule
